mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory interface; sits between the pipeline MEM stage and the byte-addressed, big-endian data memory.
- Accepts one load/store request at a time and drives mem_read, mem_write, mem_address and mem_wdata.
- Supports word and byte loads/stores. Byte stores use a read-modify-write sequence because the memory always writes 4 bytes.
- Stalls the pipeline while busy, returns a one-cycle response, and flags out-of-window addresses.

---
 rtl/mem_access_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: serialises one load/store at a time onto a big-endian,
// word-wide memory, using read-modify-write for byte stores.
module mem_access_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter logic [31:0] MEM_BYTES = 32'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + MEM_BYTES - 32'd1;

    state_t      state_reg;
    logic        write_reg;
    logic        byte_reg;
    logic        fault_reg;
    logic [29:0] word_addr_reg;
    logic [1:0]  off_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rd_buf_reg;

    logic        req_in_range;
    logic [31:0] merge_word;
    logic [7:0]  lane_bytes [4];
    logic [7:0]  sel_byte;

    // Full 32-bit unsigned window compare; word accesses are checked on the raw
    // address, which is equivalent because the window is word aligned.
    assign req_in_range = (req_addr >= BASE_ADDR) && (req_addr <= LAST_ADDR);

    // Big-endian lane mapping: offset 0 is the most significant byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_bytes[gi] = rd_buf_reg[31-8*gi -: 8];
        assign merge_word[31-8*gi -: 8] =
            (off_reg == 2'(gi)) ? wdata_reg[7:0] : rd_buf_reg[31-8*gi -: 8];
    end

    assign sel_byte = lane_bytes[off_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            write_reg     <= 1'b0;
            byte_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            word_addr_reg <= '0;
            off_reg       <= '0;
            wdata_reg     <= '0;
            rd_buf_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg     <= req_write;
                        byte_reg      <= req_byte;
                        word_addr_reg <= req_addr[31:2];
                        off_reg       <= req_addr[1:0];
                        wdata_reg     <= req_wdata;
                        fault_reg     <= ~req_in_range;
                        if (!req_in_range)
                            state_reg <= RESP;
                        else if (req_write && !req_byte)
                            state_reg <= WR;
                        else
                            state_reg <= RD;
                    end
                end
                RD: begin
                    rd_buf_reg <= mem_rdata;
                    state_reg  <= (write_reg && byte_reg) ? WR : RESP;
                end
                WR:      state_reg <= RESP;
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Bus strobes come straight from the state register so an asynchronous
    // reset withdraws a pending write before the memory can commit it.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        resp_valid  = 1'b0;
        addr_fault  = 1'b0;
        resp_rdata  = '0;
        case (state_reg)
            RD: begin
                mem_read    = 1'b1;
                mem_address = {word_addr_reg, 2'b00};
            end
            WR: begin
                mem_write   = 1'b1;
                mem_address = {word_addr_reg, 2'b00};
                mem_wdata   = byte_reg ? merge_word : wdata_reg;
            end
            RESP: begin
                resp_valid = 1'b1;
                addr_fault = fault_reg;
                if (!fault_reg && !write_reg)
                    resp_rdata = byte_reg ? {24'h0, sel_byte} : rd_buf_reg;
            end
            default: ;
        endcase
    end

    assign stall = ((state_reg == IDLE) && req_valid) ||
                   (state_reg == RD) || (state_reg == WR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized bench for mem_access_ctrl against a word-array
// reference of the data memory and the request/response rules.
module tb_mem_access_ctrl;

    localparam logic [31:0] BASE = 32'd1024;
    localparam logic [31:0] BYTES = 32'd256;
    localparam logic [31:0] LAST = BASE + BYTES - 32'd1;
    localparam int NW = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_byte;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, addr_fault, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;

    logic [31:0] mem     [NW];
    logic [31:0] ref_mem [NW];
    logic        load_mem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.BASE_ADDR(BASE), .MEM_BYTES(BYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .addr_fault(addr_fault), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic fault_of(input logic [31:0] a);
        return (a < BASE) || (a > LAST);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] off,
                                             input logic [7:0] b);
        int sh;
        sh = (3 - int'(off)) * 8;
        return (w & ~(32'hFF << sh)) | ({24'h0, b} << sh);
    endfunction

    function automatic logic [31:0] get_byte(input logic [31:0] w, input logic [1:0] off);
        int sh;
        sh = (3 - int'(off)) * 8;
        return (w >> sh) & 32'hFF;
    endfunction

    // Behavioural data memory: combinational read, commit on the rising edge.
    assign mem_rdata = (mem_read && !fault_of(mem_address)) ? mem[idx_of(mem_address)] : 32'h0;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < NW; i++) mem[i] <= ref_mem[i];
        end else if (mem_write && !fault_of(mem_address)) begin
            mem[idx_of(mem_address)] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic b, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd_o, output logic flt_o);
        logic        flt;
        int          idx, lat, exp_rd_c, exp_wr_c, got, n_rd, n_wr, rd_c, wr_c;
        logic [31:0] exp_data, new_word, wr_data, wr_addr, rd_addr, aligned;
        flt      = fault_of(a);
        idx      = flt ? 0 : idx_of(a);
        aligned  = {a[31:2], 2'b00};
        lat      = flt ? 1 : ((w && b) ? 3 : 2);
        exp_data = 32'h0;
        new_word = ref_mem[idx];
        if (!flt && !w) exp_data = b ? get_byte(ref_mem[idx], a[1:0]) : ref_mem[idx];
        if (!flt && w)  new_word = b ? put_byte(ref_mem[idx], a[1:0], d[7:0]) : d;
        exp_rd_c = (!flt && (!w || b)) ? 1 : 0;
        exp_wr_c = (!flt && w) ? (b ? 2 : 1) : 0;
        got = 0; n_rd = 0; n_wr = 0; rd_c = 0; wr_c = 0;
        wr_data = '0; wr_addr = '0; rd_addr = '0; rd_o = '0; flt_o = 1'b0;

        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
        #1 chk("stall_c0", 32'(stall), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 6 && got == 0; cyc++) begin
            @(negedge clk);
            if (cyc <= lat) chk("stall", 32'(stall), 32'(cyc < lat));
            chk("rd_and_wr", 32'(mem_read & mem_write), 32'd0);
            if (mem_read)  begin n_rd++; rd_c = cyc; rd_addr = mem_address; end
            if (mem_write) begin n_wr++; wr_c = cyc; wr_addr = mem_address; wr_data = mem_wdata; end
            if (resp_valid) begin
                got   = cyc;
                rd_o  = resp_rdata;
                flt_o = addr_fault;
                chk("resp_bus_idle", mem_address | mem_wdata, 32'd0);
            end
        end
        chk("resp_cycle", 32'(got), 32'(lat));
        chk("rdata", rd_o, exp_data);
        chk("fault", 32'(flt_o), 32'(flt));
        chk("read_count", 32'(n_rd), 32'(exp_rd_c != 0));
        chk("write_count", 32'(n_wr), 32'(exp_wr_c != 0));
        if (exp_rd_c != 0) begin
            chk("read_cycle", 32'(rd_c), 32'(exp_rd_c));
            chk("read_addr", rd_addr, aligned);
        end
        if (exp_wr_c != 0) begin
            chk("write_cycle", 32'(wr_c), 32'(exp_wr_c));
            chk("write_addr", wr_addr, aligned);
            chk("write_data", wr_data, new_word);
        end
        if (!flt && w) begin
            ref_mem[idx] = new_word;
            chk("mem_word", mem[idx], new_word);
        end
        $display("txn write=%0d byte=%0d addr=%0d wdata=%h -> rdata=%h fault=%0d resp_cycle=%0d",
                 w, b, a, d, rd_o, flt_o, got);
    endtask

    logic [31:0] r;
    logic        f;
    logic        rw, rb;
    logic [31:0] ra, rd;
    int          sel;

    initial begin
        rst = 1'b1; load_mem = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < NW; i++) ref_mem[i] = $urandom;
        load_mem = 1'b1;
        repeat (2) @(posedge clk);
        #1 load_mem = 1'b0;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_strobes", 32'({mem_read, mem_write, addr_fault}), 32'd0);
        chk("rst_bus", mem_address | mem_wdata | resp_rdata, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Word store then load, plus unaligned word load.
        do_req(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, r, f);
        do_req(1'b0, 1'b0, 32'd1028, 32'h0, r, f);
        chk("dir_word_load", r, 32'hDEADBEEF);
        chk("dir_word_fault", 32'(f), 32'd0);
        do_req(1'b0, 1'b0, 32'd1031, 32'h0, r, f);
        chk("dir_unaligned", r, 32'hDEADBEEF);

        // Byte store read-modify-write and byte loads.
        do_req(1'b1, 1'b0, 32'd1032, 32'h11223344, r, f);
        do_req(1'b1, 1'b1, 32'd1034, 32'h000000AA, r, f);
        chk("dir_rmw_word", mem[2], 32'h1122AA44);
        do_req(1'b0, 1'b1, 32'd1033, 32'h0, r, f);
        chk("dir_byte_1033", r, 32'h00000022);
        do_req(1'b0, 1'b1, 32'd1035, 32'h0, r, f);
        chk("dir_byte_1035", r, 32'h00000044);

        // Window boundaries.
        do_req(1'b0, 1'b0, 32'd1020, 32'h0, r, f);
        chk("dir_fault_1020", 32'(f), 32'd1);
        do_req(1'b1, 1'b0, 32'd1280, 32'h12345678, r, f);
        chk("dir_fault_1280", 32'(f), 32'd1);
        do_req(1'b0, 1'b0, 32'd1276, 32'h0, r, f);
        chk("dir_last_word", 32'(f), 32'd0);

        // Reset during the read phase of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_addr = 32'd1033; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rstrd_in_rd", 32'(mem_read), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rstrd_stall", 32'(stall), 32'd0);
        chk("rstrd_strobes", 32'({mem_read, mem_write, resp_valid, addr_fault}), 32'd0);
        chk("rstrd_bus", mem_address | mem_wdata | resp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rstrd_mem", mem[2], ref_mem[2]);
        do_req(1'b0, 1'b0, 32'd1032, 32'h0, r, f);
        chk("rstrd_reload", r, 32'h1122AA44);

        // Reset during the write phase: write withdrawn before the edge.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_addr = 32'd1037; req_wdata = 32'h66;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 chk("rstwr_in_wr", 32'(mem_write), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rstwr_write_drop", 32'(mem_write), 32'd0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rstwr_mem", mem[3], ref_mem[3]);

        // Request held through RESP is taken only once back in IDLE.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'd1028; req_wdata = '0;
        @(negedge clk) chk("b2b_c1_read", 32'(mem_read), 32'd1);
        @(negedge clk) chk("b2b_c2_resp", 32'({resp_valid, stall}), 32'b10);
        @(negedge clk) chk("b2b_c3_idle", 32'({resp_valid, stall, mem_read}), 32'b010);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk) chk("b2b_c4_read", 32'(mem_read), 32'd1);
        @(negedge clk) chk("b2b_c5_resp", 32'(resp_valid), 32'd1);
        chk("b2b_c5_rdata", resp_rdata, ref_mem[1]);
        $display("txn back-to-back load addr=1028 rdata=%h", resp_rdata);

        // Randomized traffic, biased toward the window edges.
        for (int n = 0; n < 60; n++) begin
            rw  = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel == 0)      ra = BASE - 32'($urandom_range(1, 8));
            else if (sel == 1) ra = LAST + 32'($urandom_range(1, 8));
            else if (sel == 2) ra = $urandom;
            else if (sel == 3) ra = LAST - 32'($urandom_range(0, 3));
            else               ra = BASE + 32'($urandom_range(0, 255));
            rd = $urandom;
            do_req(rw, rb, ra, rd, r, f);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
